instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Dual-issue instruction queue between the instruction-cache fetch stage and decode. Fetch pushes up to two instruction/PC pairs per cycle. Decode pops up to two per cycle and receives the head pair as its slot-1/slot-2 instruction words and PCs. A flush, raised when decode resolves a jump or branch redirect, empties the queue in one cycle so that wrong-path words never reach decode.

## Interface
- DEPTH, 16, number of entries; power of two, at least 4
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  discard all entries (redirect from decode)
- write_en1  input  1  push entry 1 this cycle
- write_en2  input  1  push entry 2 this cycle; honoured only together with write_en1
- write_inst1, write_inst2  input  32 each  instruction words, entry 1 older
- write_pc1, write_pc2  input  32 each  PCs of the pushed words
- read_en1  input  1  decode consumes head entry
- read_en2  input  1  decode consumes the second entry; honoured only together with read_en1
- read_inst1, read_inst2  output  32 each  head and head+1 instruction words
- read_pc1, read_pc2  output  32 each  head and head+1 PCs
- empty  output  1  count == 0
- almost_empty  output  1  count == 1 (slot 2 invalid)
- full  output  1  free slots < 2; fetch must not push

## Operation
- Storage:
  - DEPTH x 64-bit array of {pc, inst}.
  - Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
- Accepted write count:
  - wr_n = 2 if write_en1 & write_en2; 1 if write_en1 only; 0 otherwise.
  - wr_n is forced to 0 when full = 1. The fetch stage is responsible for re-presenting dropped words.
- Accepted read count:
  - rd_n = 2 if read_en1 & read_en2 & count >= 2; 1 if read_en1 & count >= 1; 0 otherwise.
  - read_en2 with only one entry present pops exactly one entry.
  - A read while empty is ignored.
- Update: entry 1 is written at wptr and entry 2 at wptr+1 (mod DEPTH). The update is wptr += wr_n, rptr += rd_n, count += wr_n - rd_n.
- Simultaneous read and write in the same cycle are both honoured. The full flag uses the pre-update count, so a full queue that is being drained still rejects writes that cycle.
- Flush:
  - On flush = 1, the next state is wptr = rptr = count = 0 and all writes and reads that cycle are discarded.
  - Flush has priority over everything except reset.
  - Delay-slot preservation is not this block's job; fetch re-supplies any delay slot after the redirect.
- Outputs (show-ahead, combinational from registered state):
  - read_inst1/read_pc1 = mem[rptr] when count >= 1, else 0.
  - read_inst2/read_pc2 = mem[rptr+1] when count >= 2, else 0.
- Array contents are not reset; only the pointers and count are reset.

## Timing
- Reset (resetn = 0, asynchronous): pointers and count go to 0. Outputs are then empty = 1, almost_empty = 0, full = 0, and all read_* = 0 immediately, without waiting for a clock edge.
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible on read_inst* after edge N and can be popped in cycle N+1.
- Flags change only on clk edges or reset.
- After a flush edge: empty = 1, and the first post-flush push is readable one cycle later.
- Wrap-around: with rptr = DEPTH-1 and count >= 2, read_inst2 comes from mem[0].
- Dual write with wptr = DEPTH-1 places entry 2 at index 0.

## Test plan
- Reset, then dual-push {0x24020001 @ 0xBFC00000, 0x24030002 @ 0xBFC00004}. One cycle later: read_inst1 = 0x24020001, read_pc2 = 0xBFC00004, empty = 0, almost_empty = 0.
- Push 15 single entries (DEPTH = 16). Expect full = 1, and a further dual push is dropped with count staying 15. Then read_en1 & read_en2 with no write: count becomes 13 and full = 0.
- With count = 1, assert read_en1 & read_en2. Only one entry is popped and empty = 1 next cycle. read_inst2 reads 0 whenever almost_empty = 1.
- Fill to count = 8, then in the same cycle flush = 1, dual write, and dual read. Next cycle: empty = 1 and all read_* = 0. A push the following cycle is readable one cycle later.
- Wrap: set wptr = 15 via 15 single push/pop pairs, then dual-push PCs 0x100/0x104. Check read_pc1 = 0x100 and read_pc2 = 0x104, sourced from mem[15] and mem[0].
- Assert resetn low mid-stream with count = 5, asynchronously between edges. empty = 1 and outputs = 0 without any clk edge. Release resetn and resume normal pushes.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch/decode handshake bundle for the dual-issue instruction queue.
// The queue itself is the slave; the fetch/decode side is the master.
interface instr_fetch_queue_if;
    logic        flush;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_inst1;
    logic [31:0] write_inst2;
    logic [31:0] write_pc1;
    logic [31:0] write_pc2;
    logic        read_en1;
    logic        read_en2;
    logic [31:0] read_inst1;
    logic [31:0] read_inst2;
    logic [31:0] read_pc1;
    logic [31:0] read_pc2;
    logic        empty;
    logic        almost_empty;
    logic        full;

    modport slave (
        input  flush, write_en1, write_en2, write_inst1, write_inst2,
               write_pc1, write_pc2, read_en1, read_en2,
        output read_inst1, read_inst2, read_pc1, read_pc2,
               empty, almost_empty, full
    );

    modport master (
        output flush, write_en1, write_en2, write_inst1, write_inst2,
               write_pc1, write_pc2, read_en1, read_en2,
        input  read_inst1, read_inst2, read_pc1, read_pc2,
               empty, almost_empty, full
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Dual-issue show-ahead instruction queue between fetch and decode.
// Up to two pushes and two pops per cycle; flush empties it in one cycle.
module instr_fetch_queue #(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               resetn,
    instr_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] P_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_TWO  = {{(CW-2){1'b0}}, 2'b10};
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH) - C_ONE;

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic [1:0]    w_wr_n;
    logic [1:0]    w_rd_n;
    logic [AW-1:0] w_wptr_p1;
    logic [AW-1:0] w_rptr_p1;
    logic [63:0]   w_head;
    logic [63:0]   w_next;

    // Fewer than two free slots: a single push could still fit but fetch always pairs.
    assign w_full    = (r_count >= C_FULL);
    assign w_wptr_p1 = r_wptr + P_ONE;
    assign w_rptr_p1 = r_rptr + P_ONE;
    assign w_head    = r_mem[r_rptr];
    assign w_next    = r_mem[w_rptr_p1];

    // Accepted push count, gated by the pre-update full flag.
    always_comb begin
        w_wr_n = 2'd0;
        if (w_full) begin
            w_wr_n = 2'd0;
        end else if (bus.write_en1 && bus.write_en2) begin
            w_wr_n = 2'd2;
        end else if (bus.write_en1) begin
            w_wr_n = 2'd1;
        end else begin
            w_wr_n = 2'd0;
        end
    end

    // Accepted pop count, limited to what is actually present.
    always_comb begin
        w_rd_n = 2'd0;
        if (bus.read_en1 && bus.read_en2 && (r_count >= C_TWO)) begin
            w_rd_n = 2'd2;
        end else if (bus.read_en1 && (r_count >= C_ONE)) begin
            w_rd_n = 2'd1;
        end else begin
            w_rd_n = 2'd0;
        end
    end

    // Storage array write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!bus.flush) begin
            if (w_wr_n != 2'd0) begin
                r_mem[r_wptr] <= {bus.write_pc1, bus.write_inst1};
            end
            if (w_wr_n == 2'd2) begin
                r_mem[w_wptr_p1] <= {bus.write_pc2, bus.write_inst2};
            end
        end
    end

    // Pointer and occupancy update; flush discards that cycle's traffic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= C_ZERO;
        end else if (bus.flush) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= C_ZERO;
        end else begin
            r_wptr  <= r_wptr + AW'(w_wr_n);
            r_rptr  <= r_rptr + AW'(w_rd_n);
            r_count <= r_count + CW'(w_wr_n) - CW'(w_rd_n);
        end
    end

    // Show-ahead outputs; invalid slots read as zero so stale words never leak.
    always_comb begin
        bus.read_inst1 = 32'd0;
        bus.read_pc1   = 32'd0;
        bus.read_inst2 = 32'd0;
        bus.read_pc2   = 32'd0;
        if (r_count >= C_ONE) begin
            bus.read_inst1 = w_head[31:0];
            bus.read_pc1   = w_head[63:32];
        end else begin
            bus.read_inst1 = 32'd0;
            bus.read_pc1   = 32'd0;
        end
        if (r_count >= C_TWO) begin
            bus.read_inst2 = w_next[31:0];
            bus.read_pc2   = w_next[63:32];
        end else begin
            bus.read_inst2 = 32'd0;
            bus.read_pc2   = 32'd0;
        end
    end

    assign bus.empty        = (r_count == C_ZERO);
    assign bus.almost_empty = (r_count == C_ONE);
    assign bus.full         = w_full;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH = 16).
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_fetch_queue_if bus();
    instr_fetch_queue #(.DEPTH(16)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    task automatic drive(input logic w1, input logic w2,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic [31:0] i2, input logic [31:0] p2,
                         input logic r1, input logic r2, input logic fl);
        bus.write_en1 = w1;  bus.write_en2 = w2;
        bus.write_inst1 = i1; bus.write_pc1 = p1;
        bus.write_inst2 = i2; bus.write_pc2 = p2;
        bus.read_en1 = r1;   bus.read_en2 = r2;
        bus.flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] i, input logic [31:0] p);
        drive(1'b1, 1'b0, i, p, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic do_flush();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        #3;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL reset_almost_empty: got %b want 0", bus.almost_empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.read_inst1 !== 32'd0) begin errors++; $display("FAIL reset_inst1: got %h want 0", bus.read_inst1); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_dual_push();
        drive(1'b1, 1'b1, 32'h24020001, 32'hBFC00000, 32'h24030002, 32'hBFC00004, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (bus.read_inst1 !== 32'h24020001) begin errors++; $display("FAIL dual_inst1: got %h want 24020001", bus.read_inst1); end
        checks++; if (bus.read_pc1 !== 32'hBFC00000) begin errors++; $display("FAIL dual_pc1: got %h want bfc00000", bus.read_pc1); end
        checks++; if (bus.read_inst2 !== 32'h24030002) begin errors++; $display("FAIL dual_inst2: got %h want 24030002", bus.read_inst2); end
        checks++; if (bus.read_pc2 !== 32'hBFC00004) begin errors++; $display("FAIL dual_pc2: got %h want bfc00004", bus.read_pc2); end
        checks++; if (bus.empty !== 1'b0 || bus.almost_empty !== 1'b0) begin errors++; $display("FAIL dual_flags: got empty=%b ae=%b want 0 0", bus.empty, bus.almost_empty); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL dual_pop_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_full();
        do_flush();
        for (int i = 0; i < 14; i++) push1(32'h1000 + i, 32'h2000 + 4 * i);
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_at14: got %b want 0", bus.full); end
        push1(32'h100E, 32'h2038);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_at15: got %b want 1", bus.full); end
        checks++; if (dut.r_count !== 5'd15) begin errors++; $display("FAIL full_count15: got %0d want 15", dut.r_count); end
        drive(1'b1, 1'b1, 32'hDEAD0001, 32'h0, 32'hDEAD0002, 32'h4, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (dut.r_count !== 5'd15) begin errors++; $display("FAIL full_drop_count: got %0d want 15", dut.r_count); end
        checks++; if (bus.read_inst1 !== 32'h1000) begin errors++; $display("FAIL full_drop_head: got %h want 1000", bus.read_inst1); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        checks++; if (dut.r_count !== 5'd13) begin errors++; $display("FAIL full_pop2_count: got %0d want 13", dut.r_count); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_pop2_flag: got %b want 0", bus.full); end
        checks++; if (bus.read_inst1 !== 32'h1002 || bus.read_inst2 !== 32'h1003) begin errors++; $display("FAIL full_pop2_head: got %h %h want 1002 1003", bus.read_inst1, bus.read_inst2); end
        push1(32'h1100, 32'h3000);
        push1(32'h1101, 32'h3004);
        drive(1'b1, 1'b1, 32'hBEEF0001, 32'h0, 32'hBEEF0002, 32'h4, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (dut.r_count !== 5'd14) begin errors++; $display("FAIL full_drain_reject: got %0d want 14", dut.r_count); end
        checks++; if (bus.read_inst1 !== 32'h1003) begin errors++; $display("FAIL full_drain_head: got %h want 1003", bus.read_inst1); end
    endtask

    task automatic test_almost_one();
        do_flush();
        push1(32'h000000A1, 32'h40);
        checks++; if (bus.almost_empty !== 1'b1 || bus.empty !== 1'b0) begin errors++; $display("FAIL one_flags: got ae=%b empty=%b want 1 0", bus.almost_empty, bus.empty); end
        checks++; if (bus.read_inst1 !== 32'hA1) begin errors++; $display("FAIL one_inst1: got %h want a1", bus.read_inst1); end
        checks++; if (bus.read_inst2 !== 32'd0 || bus.read_pc2 !== 32'd0) begin errors++; $display("FAIL one_slot2_zero: got %h %h want 0 0", bus.read_inst2, bus.read_pc2); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        checks++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b0) begin errors++; $display("FAIL one_pop_flags: got empty=%b ae=%b want 1 0", bus.empty, bus.almost_empty); end
        checks++; if (dut.r_count !== 5'd0) begin errors++; $display("FAIL one_pop_count: got %0d want 0", dut.r_count); end
        checks++; if (bus.read_inst1 !== 32'd0) begin errors++; $display("FAIL one_pop_inst1: got %h want 0", bus.read_inst1); end
    endtask

    task automatic test_flush();
        do_flush();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h3000 + 2 * k, 32'h4000 + 8 * k, 32'h3001 + 2 * k, 32'h4004 + 8 * k, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        checks++; if (dut.r_count !== 5'd8) begin errors++; $display("FAIL flush_fill8: got %0d want 8", dut.r_count); end
        drive(1'b1, 1'b1, 32'hBAD00001, 32'h0, 32'hBAD00002, 32'h4, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        checks++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL flush_flags: got e=%b ae=%b f=%b want 1 0 0", bus.empty, bus.almost_empty, bus.full); end
        checks++; if (bus.read_inst1 !== 32'd0 || bus.read_pc1 !== 32'd0) begin errors++; $display("FAIL flush_slot1_zero: got %h %h want 0 0", bus.read_inst1, bus.read_pc1); end
        checks++; if (bus.read_inst2 !== 32'd0 || bus.read_pc2 !== 32'd0) begin errors++; $display("FAIL flush_slot2_zero: got %h %h want 0 0", bus.read_inst2, bus.read_pc2); end
        push1(32'h55, 32'h300);
        checks++; if (bus.read_inst1 !== 32'h55 || bus.read_pc1 !== 32'h300) begin errors++; $display("FAIL flush_repush: got %h %h want 55 300", bus.read_inst1, bus.read_pc1); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL flush_repush_ae: got %b want 1", bus.almost_empty); end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int i = 0; i < 15; i++) begin
            push1(32'h500 + i, 32'h600 + 4 * i);
            drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
            tick();
            idle();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_pre_empty: got %b want 1", bus.empty); end
        drive(1'b1, 1'b1, 32'h11, 32'h100, 32'h22, 32'h104, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (bus.read_pc1 !== 32'h100 || bus.read_pc2 !== 32'h104) begin errors++; $display("FAIL wrap_pcs: got %h %h want 100 104", bus.read_pc1, bus.read_pc2); end
        checks++; if (bus.read_inst1 !== 32'h11 || bus.read_inst2 !== 32'h22) begin errors++; $display("FAIL wrap_insts: got %h %h want 11 22", bus.read_inst1, bus.read_inst2); end
        checks++; if (dut.r_mem[0] !== {32'h104, 32'h22}) begin errors++; $display("FAIL wrap_mem0: got %h want 0000010400000022", dut.r_mem[0]); end
        push1(32'h33, 32'h108);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        checks++; if (bus.read_pc1 !== 32'h108 || bus.almost_empty !== 1'b1) begin errors++; $display("FAIL wrap_after: got pc=%h ae=%b want 108 1", bus.read_pc1, bus.almost_empty); end
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int i = 0; i < 5; i++) push1(32'h700 + i, 32'h800 + 4 * i);
        checks++; if (dut.r_count !== 5'd5) begin errors++; $display("FAIL areset_fill5: got %0d want 5", dut.r_count); end
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL areset_flags: got e=%b ae=%b f=%b want 1 0 0", bus.empty, bus.almost_empty, bus.full); end
        checks++; if (bus.read_inst1 !== 32'd0 || bus.read_pc1 !== 32'd0 || bus.read_inst2 !== 32'd0 || bus.read_pc2 !== 32'd0) begin errors++; $display("FAIL areset_outputs: got %h %h %h %h want 0", bus.read_inst1, bus.read_pc1, bus.read_inst2, bus.read_pc2); end
        #1;
        resetn = 1'b1;
        tick();
        drive(1'b1, 1'b1, 32'h900, 32'h800, 32'h901, 32'h804, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checks++; if (bus.read_inst1 !== 32'h900 || bus.read_pc2 !== 32'h804) begin errors++; $display("FAIL areset_resume: got %h %h want 900 804", bus.read_inst1, bus.read_pc2); end
        checks++; if (bus.almost_empty !== 1'b0 || bus.empty !== 1'b0) begin errors++; $display("FAIL areset_resume_flags: got ae=%b e=%b want 0 0", bus.almost_empty, bus.empty); end
    endtask

    initial begin
        test_reset();
        test_dual_push();
        test_full();
        test_almost_one();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
